// File: rtl/tcbm_responder_pkg.sv
// Shared TCBM definitions: transfer code bytes, responder state encoding and
// code classification helpers.
package tcbm_responder_pkg;

  localparam logic [7:0] TCBM_CMD = 8'h81;
  localparam logic [7:0] TCBM_WR  = 8'h82;
  localparam logic [7:0] TCBM_RD  = 8'h83;
  localparam logic [7:0] TCBM_ST  = 8'h84;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CODE_REL  = 3'd1,
    DATA_WAIT = 3'd2,
    WR_HOLD   = 3'd3,
    RD_HOLD   = 3'd4,
    DATA_REL  = 3'd5
  } state_t;

  function automatic logic is_legal(input logic [7:0] code);
    return code inside {TCBM_CMD, TCBM_WR, TCBM_RD, TCBM_ST};
  endfunction

  function automatic logic is_read(input logic [7:0] code);
    return code inside {TCBM_RD, TCBM_ST};
  endfunction

  // 0x81..0x84 map onto 0..3, the index reported on rx_code/tx_code.
  function automatic logic [1:0] code_idx(input logic [7:0] code);
    return 2'(code[2:0] - 3'd1);
  endfunction

endpackage

// File: rtl/tcbm_responder_sync_ff.sv
// Parameterised-depth synchroniser for an asynchronous single-bit input;
// resets to 1 so an idle active-low strobe looks inactive.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour, forming a real shift chain.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) chain <= '1;
    else       chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/tcbm_responder.sv
// Drive-side TCBM responder: answers the host's DAV_n/ACK_n handshake and
// bridges write bytes out and read bytes in over valid/ready streams.
module tcbm_responder
  import tcbm_responder_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 65535,
  parameter int CNT_WIDTH   = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       dav_n,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       ack_n,
  output logic [1:0] status,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic [1:0] rx_code,
  input  logic       rx_ready,
  output logic       tx_req,
  output logic [1:0] tx_code,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic [1:0] tx_status,
  output logic       tx_ready,
  output logic       err
);

  localparam logic [CNT_WIDTH-1:0] TO_LAST = CNT_WIDTH'(TIMEOUT - 1);

  logic dav_s, dav_prev, armed, fall, rise;
  logic [SYNC_STAGES-1:0] settle;

  sync_ff #(.STAGES(SYNC_STAGES)) u_dav_sync (
    .clock (clock),
    .reset (reset),
    .d     (dav_n),
    .q     (dav_s)
  );

  // Edges are only trusted once the chain holds real pin samples and DAV has
  // been seen high, so a DAV already low at reset exit is not taken as a fall.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      settle   <= '0;
      armed    <= 1'b0;
      dav_prev <= 1'b1;
    end else begin
      settle   <= {settle[SYNC_STAGES-2:0], 1'b1};
      armed    <= armed | (settle[SYNC_STAGES-1] & dav_s);
      dav_prev <= dav_s;
    end
  end

  assign fall = armed &  dav_prev & ~dav_s;
  assign rise = armed & ~dav_prev &  dav_s;

  state_t               state, state_d;
  logic                 void_q, void_d, rd_q, rd_d;
  logic [1:0]           code_q, code_d;
  logic [CNT_WIDTH-1:0] cnt, cnt_d;
  logic                 counting;
  logic                 ack_n_d, data_oe_d, rx_valid_d, tx_req_d, tx_ready_d, err_d;
  logic [7:0]           data_out_d, rx_data_d;
  logic [1:0]           status_d, rx_code_d, tx_code_d;

  assign counting = (state == CODE_REL) || (state == DATA_WAIT) || (state == DATA_REL);

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state;
    void_d     = void_q;
    rd_d       = rd_q;
    code_d     = code_q;
    ack_n_d    = ack_n;
    data_oe_d  = data_oe;
    data_out_d = data_out;
    status_d   = status;
    rx_valid_d = rx_valid;
    rx_data_d  = rx_data;
    rx_code_d  = rx_code;
    tx_req_d   = tx_req;
    tx_code_d  = tx_code;
    tx_ready_d = 1'b0;
    err_d      = 1'b0;

    case (state)
      IDLE: if (fall) begin
        code_d  = code_idx(data_in);
        rd_d    = is_read(data_in);
        void_d  = !is_legal(data_in);
        err_d   = !is_legal(data_in);
        ack_n_d = 1'b0;
        state_d = CODE_REL;
      end
      CODE_REL: if (rise) begin
        ack_n_d = 1'b1;
        if (void_q) begin
          state_d = IDLE;
        end else begin
          state_d = DATA_WAIT;
          if (rd_q) begin
            tx_req_d  = 1'b1;
            tx_code_d = code_q;
          end
        end
      end
      DATA_WAIT: if (fall) begin
        if (rd_q) begin
          state_d = RD_HOLD;
        end else begin
          rx_data_d  = data_in;
          rx_code_d  = code_q;
          rx_valid_d = 1'b1;
          state_d    = WR_HOLD;
        end
      end
      WR_HOLD: if (rx_valid && rx_ready) begin
        rx_valid_d = 1'b0;
        ack_n_d    = 1'b0;
        state_d    = DATA_REL;
      end
      // tx_ready is high exactly the cycle after the byte was loaded, so it
      // doubles as the "data has been stable for a clock" marker.
      RD_HOLD: if (tx_ready) begin
        ack_n_d = 1'b0;
        state_d = DATA_REL;
      end else if (tx_valid) begin
        tx_ready_d = 1'b1;
        data_out_d = tx_data;
        status_d   = tx_status;
        data_oe_d  = 1'b1;
        tx_req_d   = 1'b0;
      end
      DATA_REL: if (rise) begin
        ack_n_d   = 1'b1;
        data_oe_d = 1'b0;
        status_d  = 2'b00;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (TIMEOUT != 0 && counting && cnt == TO_LAST) begin
      err_d      = 1'b1;
      ack_n_d    = 1'b1;
      data_oe_d  = 1'b0;
      rx_valid_d = 1'b0;
      tx_req_d   = 1'b0;
      state_d    = IDLE;
    end

    if (state_d != state) cnt_d = '0;
    else if (counting)    cnt_d = cnt + CNT_WIDTH'(1);
    else                  cnt_d = cnt;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      void_q   <= 1'b0;
      rd_q     <= 1'b0;
      code_q   <= 2'b00;
      cnt      <= '0;
      ack_n    <= 1'b1;
      data_oe  <= 1'b0;
      data_out <= 8'h00;
      status   <= 2'b00;
      rx_valid <= 1'b0;
      rx_data  <= 8'h00;
      rx_code  <= 2'b00;
      tx_req   <= 1'b0;
      tx_code  <= 2'b00;
      tx_ready <= 1'b0;
      err      <= 1'b0;
    end else begin
      void_q   <= void_d;
      rd_q     <= rd_d;
      code_q   <= code_d;
      cnt      <= cnt_d;
      ack_n    <= ack_n_d;
      data_oe  <= data_oe_d;
      data_out <= data_out_d;
      status   <= status_d;
      rx_valid <= rx_valid_d;
      rx_data  <= rx_data_d;
      rx_code  <= rx_code_d;
      tx_req   <= tx_req_d;
      tx_code  <= tx_code_d;
      tx_ready <= tx_ready_d;
      err      <= err_d;
    end
  end

endmodule
